// File: rtl/cook_sequencer.sv
// cook_sequencer: microwave cook-time sequencer with BCD keypad entry, per-second countdown and door-interlocked magnetron
// Ports: clk/rst (sync, active-high); startn/stopn/clearn active-low debounced buttons;
// door_closed interlock; key_valid/key_digit keypad strobe; min_tens..sec_ones BCD time;
// mag_on magnetron enable; done completion flag; state IDLE=0 COOKING=1 PAUSED=2 DONE=3
module cook_sequencer #(
    parameter int TICKS_PER_SEC = 100,
    parameter int DONE_HOLD = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       mag_on,
    output logic       done,
    output logic [2:0] state
);
    localparam int HOLD = DONE_HOLD * TICKS_PER_SEC;
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int HW = $clog2(HOLD);
    typedef enum logic [2:0] {IDLE = 3'd0, COOKING = 3'd1, PAUSED = 3'd2, DONE = 3'd3} state_t;
    state_t cur, nxt;
    logic startn_q, stopn_q, clearn_q;
    logic [PW-1:0] pre, pre_n;
    logic [HW-1:0] cnt, cnt_n;
    logic [3:0] mt_n, mo_n, st_n, so_n, dmt, dmo, dst, dso;
    logic start_p, stop_p, clear_p, tick, soz, sz, mz;
    assign start_p = startn_q & ~startn;
    assign stop_p = stopn_q & ~stopn;
    assign clear_p = clearn_q & ~clearn;
    assign tick = cur == COOKING && pre == PW'(TICKS_PER_SEC - 1);
    // Decremented time; seconds 00 borrows from minutes and reloads 59.
    assign soz = sec_ones == 4'd0;
    assign sz = soz && sec_tens == 4'd0;
    assign mz = min_ones == 4'd0;
    assign dso = soz ? 4'd9 : sec_ones - 4'd1;
    assign dst = sz ? 4'd5 : soz ? sec_tens - 4'd1 : sec_tens;
    assign dmo = !sz ? min_ones : mz ? 4'd9 : min_ones - 4'd1;
    assign dmt = sz && mz ? min_tens - 4'd1 : min_tens;
    assign mag_on = cur == COOKING && door_closed;
    assign done = cur == DONE;
    assign state = cur;
    always_comb begin
        nxt = cur;
        {mt_n, mo_n, st_n, so_n} = {min_tens, min_ones, sec_tens, sec_ones};
        pre_n = '0;
        cnt_n = '0;
        case (cur)
            IDLE: begin
                if (clear_p || stop_p)
                    {mt_n, mo_n, st_n, so_n} = '0;
                else if (start_p && door_closed && |{min_tens, min_ones, sec_tens, sec_ones})
                    nxt = COOKING;
                else if (key_valid && key_digit < 4'd10)
                    {mt_n, mo_n, st_n, so_n} = {min_ones, sec_tens, sec_ones, key_digit};
            end
            COOKING: begin
                if (clear_p) begin
                    nxt = IDLE;
                    {mt_n, mo_n, st_n, so_n} = '0;
                end else if (stop_p || !door_closed)
                    nxt = PAUSED;
                else if (tick) begin
                    {mt_n, mo_n, st_n, so_n} = {dmt, dmo, dst, dso};
                    nxt = {dmt, dmo, dst, dso} == 16'd0 ? DONE : COOKING;
                end else
                    pre_n = pre + 1'b1;
            end
            PAUSED: begin
                if (clear_p || stop_p) begin
                    nxt = IDLE;
                    {mt_n, mo_n, st_n, so_n} = '0;
                end else if (start_p && door_closed)
                    nxt = COOKING;
            end
            DONE: begin
                if (start_p || stop_p || clear_p || cnt == HW'(HOLD - 1))
                    nxt = IDLE;
                else
                    cnt_n = cnt + 1'b1;
            end
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= IDLE;
            {min_tens, min_ones, sec_tens, sec_ones} <= '0;
            pre <= '0;
            cnt <= '0;
            {startn_q, stopn_q, clearn_q} <= 3'b111;
        end else begin
            cur <= nxt;
            {min_tens, min_ones, sec_tens, sec_ones} <= {mt_n, mo_n, st_n, so_n};
            pre <= pre_n;
            cnt <= cnt_n;
            {startn_q, stopn_q, clearn_q} <= {startn, stopn, clearn};
        end
    end
endmodule
